mac_tx_arb: RTL and testbench
=============================

# mac_tx_arb

Frame-level round-robin arbiter that shares the single MAC transmit path (`mac_tx`) between several payload sources, such as the ARP responder and the UDP stack.
- It grants one requester for a whole frame and passes that requester's payload bytes to the MAC under the MAC's ready handshake.
- It enforces a minimum idle gap between frames and guards against underrun and oversize frames.
- It sits between the upper-layer engines and `mac_tx`.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..4.
- `GAP_CYCLES`, default 12: idle cycles with `out_mac_txen`=0 enforced after every frame.
- `MAX_LEN`, default 1500: maximum payload bytes per frame.

Ports:
- `in_clk`  input  1  sole clock; everything is on its rising edge.
- `in_rst`  input  1  synchronous, active-high reset.
- `in_req_valid`  input  NUM_REQ  per requester: a byte is presented.
- `in_req_data`  input  8*NUM_REQ  per requester: payload byte; requester i occupies bits [8i+7:8i].
- `in_req_last`  input  NUM_REQ  per requester: the presented byte is the last of its frame.
- `out_req_ready`  output  NUM_REQ  per requester: byte accepted this cycle.
- `out_grant`  output  NUM_REQ  one-hot owner of the current frame; 0 when no frame is in progress.
- `out_mac_txen`  output  1  frame in progress towards the MAC.
- `out_mac_txd`  output  8  payload byte towards the MAC.
- `in_mac_ready`  input  1  MAC accepts a payload byte this cycle.
- `out_underrun`  output  1  one-cycle pulse: the granted requester dropped valid mid-frame.
- `out_oversize`  output  1  one-cycle pulse: the frame exceeded `MAX_LEN` and was truncated.

## Operation
- States: IDLE, XFER, PAD, DRAIN, GAP.
- **IDLE.**
  - If any `in_req_valid` is high, pick the first requester with valid high, searching from the last grantee+1 with wrap-around.
  - Load it into `out_grant` and go to XFER.
  - Otherwise stay in IDLE.
- **XFER.**
  - `out_mac_txen`=1 and `out_mac_txd` = granted data (combinational mux).
  - `out_req_ready` = grant & `in_mac_ready`.
  - A beat occurs when granted valid=1 and `in_mac_ready`=1.
  - Each beat increments the 11-bit byte counter.
  - A beat with `in_req_last`=1 ends the frame and goes to GAP (or PAD, see Configuration).
  - If `in_mac_ready`=1 while granted valid=0, pulse `out_underrun` and go to GAP. The frame is aborted.
  - A beat that brings the count to `MAX_LEN` without last pulses `out_oversize`, drops `out_mac_txen`, and goes to DRAIN.
- **DRAIN.**
  - `out_mac_txen`=0; `out_req_ready` = grant, unconditionally.
  - Discard bytes until a beat with last, then go to GAP.
- **GAP.**
  - `out_mac_txen`=0 and `out_grant`=0.
  - Count `GAP_CYCLES` cycles, then return to IDLE.
- The round-robin pointer updates only on a grant.
- The byte counter clears on entry to XFER.
- Requests that arrive during XFER, DRAIN or GAP wait; they are never dropped.

## Timing
- Grant is registered: valid seen in IDLE at edge N gives `out_grant` and `out_mac_txen` high after edge N.
- The first beat is possible in cycle N+1.
- The data path from requester to MAC has zero latency (mux only).
- `out_mac_txen` falls on the edge after the last beat.
- The next `out_mac_txen` rise is no earlier than `GAP_CYCLES`+1 cycles after the fall.
- Reset values:
  - state IDLE;
  - `out_grant`=0;
  - `out_req_ready`=0;
  - `out_mac_txen`=0;
  - `out_mac_txd`=0 (forced 0 whenever txen=0);
  - pulses 0;
  - counters 0;
  - RR pointer = `NUM_REQ`-1, so requester 0 wins first.
- Reset asserted mid-frame takes all outputs to reset values on that edge. The MAC sees txen drop; no completion is signalled.
- Simultaneous requests resolve by round-robin only; there is no fixed priority.

## Configuration
- Macro: `MAC_TX_ARB_PAD_EN`.
- Defined:
  - A last beat with count < 46 enters PAD instead of GAP.
  - PAD holds `out_mac_txen`=1 and `out_mac_txd`=0, and counts beats on `in_mac_ready` until the count reaches 46, then goes to GAP.
  - `out_req_ready`=0 in PAD.
- Undefined:
  - The PAD state is absent; short frames go straight to GAP.

## Structure
- Shared `mac_pkg`:
  - state encoding;
  - `ETH_MIN_PAYLOAD`=46;
  - `ETH_MAX_PAYLOAD`=1500;
  - byte-counter width (11).
- Sub-module `rr_pick`: combinational round-robin selector taking the request vector and last-grant pointer and returning a one-hot grant plus an any-request flag.

## Test plan
- **Single frame:** requester 0 sends 60 bytes 0x01..0x3C with `in_mac_ready`=1 -> txen high for exactly 60 cycles, txd matches, then 12 idle cycles.
- **Contention:** both requesters assert valid together, three frames each -> grants alternate 0,1,0,1,0,1, with gap ≥12 between every pair.
- **MAC backpressure:** toggle `in_mac_ready` every cycle over a 50-byte frame -> exactly 50 beats, no duplicated or lost byte, and the requester's ready mirrors mac ready.
- **Underrun:** requester drops valid at byte 20 while mac ready=1 -> one `out_underrun` pulse, txen falls next edge, GAP runs.
- **Oversize:** 1510-byte frame -> 1500 bytes to the MAC, `out_oversize` pulse, remaining 10 bytes drained with txen=0, then GAP.
- **Pad and reset:**
  - With `MAC_TX_ARB_PAD_EN`, a 10-byte frame -> 10 data bytes then 36 zero bytes, txen held for 46 beats.
  - Reset asserted at byte 5 -> all outputs 0 on that edge, and requester 0 wins the next arbitration.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, state encoding and helpers for the MAC transmit arbiter
package mac_pkg;

  localparam int ETH_MIN_PAYLOAD = 46;
  localparam int ETH_MAX_PAYLOAD = 1500;
  localparam int CNT_W           = 11;
  localparam int PTR_W           = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XFER  = 3'd1,
    ST_PAD   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Index of the set bit of a one-hot vector of up to four requesters
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [3:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector starting after the last grantee
module rr_pick
  import mac_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_any
);

  logic w_found;

  // Walk ptr+1, ptr+2, ... with wrap-around and take the first active request
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (j == ((int'(i_ptr) + k) % NUM_REQ)) && i_req[j]) begin
          o_grant[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/mac_tx_arb.sv
// rtl/mac_tx_arb.sv - frame-level round-robin arbiter onto mac_tx; MAC_TX_ARB_PAD_EN enables short-frame padding
module mac_tx_arb
  import mac_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 12,
  parameter int MAX_LEN    = ETH_MAX_PAYLOAD
) (
  input  logic                   in_clk,
  input  logic                   in_rst,
  input  logic [NUM_REQ-1:0]     in_req_valid,
  input  logic [8*NUM_REQ-1:0]   in_req_data,
  input  logic [NUM_REQ-1:0]     in_req_last,
  output logic [NUM_REQ-1:0]     out_req_ready,
  output logic [NUM_REQ-1:0]     out_grant,
  output logic                   out_mac_txen,
  output logic [7:0]             out_mac_txd,
  input  logic                   in_mac_ready,
  output logic                   out_underrun,
  output logic                   out_oversize
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LEN);
  localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);
`ifdef MAC_TX_ARB_PAD_EN
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(ETH_MIN_PAYLOAD);
`endif

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [15:0]          r_gap_cnt, w_gap_nxt;

  logic [NUM_REQ-1:0]   w_pick;
  logic                 w_any;
  logic [PTR_W-1:0]     w_pick_idx;
  logic                 w_gnt_valid;
  logic                 w_gnt_last;
  logic [7:0]           w_gnt_data;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_enter_gap;
  logic                 w_txen;
  logic [7:0]           w_txd;
  logic [NUM_REQ-1:0]   w_ready;
  logic                 w_underrun;
  logic                 w_oversize;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_req   (in_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  assign w_pick_idx = onehot_to_idx(4'(w_pick));
  assign w_cnt_inc  = r_cnt + 1'b1;

  // Select the granted requester's valid/last/data (zero-latency mux)
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_last  = 1'b0;
    w_gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_gnt_valid = w_gnt_valid | in_req_valid[i];
        w_gnt_last  = w_gnt_last | in_req_last[i];
        w_gnt_data  = w_gnt_data | in_req_data[8*i +: 8];
      end
    end
  end

  // State, grant, round-robin pointer and counters
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_ptr     <= PTR_W'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Next-state and output decode; txd stays 0 whenever txen is low
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap_cnt;
    w_enter_gap = 1'b0;
    w_txen      = 1'b0;
    w_txd       = 8'h00;
    w_ready     = '0;
    w_underrun  = 1'b0;
    w_oversize  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_XFER;
          w_grant_nxt = w_pick;
          w_ptr_nxt   = w_pick_idx;
          w_cnt_nxt   = '0;
        end
      end

      ST_XFER: begin
        w_txen  = 1'b1;
        w_txd   = w_gnt_data;
        w_ready = r_grant & {NUM_REQ{in_mac_ready}};
        if (in_mac_ready) begin
          if (w_gnt_valid) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_gnt_last) begin
`ifdef MAC_TX_ARB_PAD_EN
              if (w_cnt_inc < MIN_CNT) w_state_nxt = ST_PAD;
              else                     w_enter_gap = 1'b1;
`else
              w_enter_gap = 1'b1;
`endif
            end else if (w_cnt_inc == MAX_CNT) begin
              w_oversize  = 1'b1;
              w_state_nxt = ST_DRAIN;
            end
          end else begin
            // Source stalled while the MAC wanted a byte: abort the frame
            w_underrun  = 1'b1;
            w_enter_gap = 1'b1;
          end
        end
      end

      ST_PAD: begin
`ifdef MAC_TX_ARB_PAD_EN
        w_txen = 1'b1;
        if (in_mac_ready) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= MIN_CNT) w_enter_gap = 1'b1;
        end
`else
        w_enter_gap = 1'b1;
`endif
      end

      ST_DRAIN: begin
        // Swallow the rest of a truncated frame regardless of MAC ready
        w_ready = r_grant;
        if (w_gnt_valid && w_gnt_last) w_enter_gap = 1'b1;
      end

      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
        else                       w_gap_nxt   = r_gap_cnt + 16'd1;
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_enter_gap) begin
      w_state_nxt = ST_GAP;
      w_grant_nxt = '0;
      w_gap_nxt   = '0;
    end
  end

  assign out_grant     = r_grant;
  assign out_req_ready = w_ready;
  assign out_mac_txen  = w_txen;
  assign out_mac_txd   = w_txd;
  assign out_underrun  = w_underrun;
  assign out_oversize  = w_oversize;

endmodule

// File: tb/tb_mac_tx_arb.sv
// tb/tb_mac_tx_arb.sv - directed self-checking bench for mac_tx_arb
module tb_mac_tx_arb;

  logic        in_clk;
  logic        in_rst;
  logic [1:0]  in_req_valid;
  logic [15:0] in_req_data;
  logic [1:0]  in_req_last;
  logic [1:0]  out_req_ready;
  logic [1:0]  out_grant;
  logic        out_mac_txen;
  logic [7:0]  out_mac_txd;
  logic        in_mac_ready;
  logic        out_underrun;
  logic        out_oversize;

  mac_tx_arb #(.NUM_REQ(2), .GAP_CYCLES(12), .MAX_LEN(1500)) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_req_valid  (in_req_valid),
    .in_req_data   (in_req_data),
    .in_req_last   (in_req_last),
    .out_req_ready (out_req_ready),
    .out_grant     (out_grant),
    .out_mac_txen  (out_mac_txen),
    .out_mac_txd   (out_mac_txd),
    .in_mac_ready  (in_mac_ready),
    .out_underrun  (out_underrun),
    .out_oversize  (out_oversize)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // source model state
  int frames [2];
  int len    [2];
  int idx    [2];
  int drop_at[2];
  bit toggle_mode;
  bit mirror_mode;

  // observations
  int txen_cyc, beats[2], drained, data_err, pad_beats, pad_err;
  int under_cnt, over_cnt, done_frames, mirror_err;
  int first_txen, last_txen, cyc, txen_after_under;
  bit pend_under, seen_fall, prev_txen;
  int idle_run, min_idle, n_gaps;
  logic [1:0] prev_grant;
  int gseq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input int k);
    return 8'((i * 128 + k + 1) & 255);
  endfunction

  task automatic clear_stats();
    txen_cyc = 0; beats[0] = 0; beats[1] = 0; drained = 0; data_err = 0;
    pad_beats = 0; pad_err = 0; under_cnt = 0; over_cnt = 0; done_frames = 0;
    mirror_err = 0; first_txen = -1; last_txen = -1; cyc = 0; txen_after_under = -1;
    pend_under = 0; seen_fall = 0; prev_txen = 0; idle_run = 0; min_idle = 1000000;
    n_gaps = 0; prev_grant = '0; gseq.delete();
  endtask

  task automatic step();
    bit hs;
    @(negedge in_clk);
    for (int i = 0; i < 2; i++) begin
      in_req_valid[i]      = (frames[i] > 0) && (idx[i] != drop_at[i]);
      in_req_data[8*i +: 8] = pat(i, idx[i]);
      in_req_last[i]       = (idx[i] == len[i] - 1);
    end
    in_mac_ready = toggle_mode ? ~in_mac_ready : 1'b1;
    #1;
    if (pend_under) begin
      txen_after_under = int'(out_mac_txen);
      pend_under = 0;
    end
    if (out_mac_txen) begin
      txen_cyc++;
      if (first_txen < 0) first_txen = cyc;
      last_txen = cyc;
      if (!prev_txen && seen_fall) begin
        n_gaps++;
        if (idle_run < min_idle) min_idle = idle_run;
      end
    end else begin
      if (prev_txen) begin
        seen_fall = 1;
        idle_run = 0;
      end
      idle_run++;
    end
    if (out_grant != 2'b00 && prev_grant == 2'b00) begin
      for (int j = 0; j < 2; j++) if (out_grant[j]) gseq.push_back(j);
    end
    if (out_underrun) begin under_cnt++; pend_under = 1; end
    if (out_oversize) over_cnt++;
    if (mirror_mode && (out_req_ready[0] !== (out_mac_txen & in_mac_ready))) mirror_err++;
    hs = 0;
    for (int i = 0; i < 2; i++) begin
      if (out_req_ready[i] && in_req_valid[i]) begin
        hs = 1;
        if (out_mac_txen) begin
          beats[i]++;
          if (out_mac_txd !== pat(i, idx[i])) data_err++;
        end else begin
          drained++;
        end
        if (in_req_last[i]) begin
          frames[i]--;
          idx[i] = 0;
          done_frames++;
        end else begin
          idx[i]++;
        end
      end
    end
    if (out_mac_txen && in_mac_ready && !hs && !out_underrun) begin
      pad_beats++;
      if (out_mac_txd !== 8'h00) pad_err++;
    end
    prev_txen  = out_mac_txen;
    prev_grant = out_grant;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic set_src(input int i, input int nf, input int l, input int drop);
    frames[i] = nf; len[i] = l; idx[i] = 0; drop_at[i] = drop;
  endtask

  task automatic do_reset();
    @(negedge in_clk);
    in_rst = 1'b1;
    in_req_valid = '0;
    @(negedge in_clk);
    in_rst = 1'b0;
  endtask

  initial begin
    in_rst = 1'b1;
    in_req_valid = '0;
    in_req_data = '0;
    in_req_last = '0;
    in_mac_ready = 1'b1;
    toggle_mode = 0;
    mirror_mode = 0;
    set_src(0, 0, 1, -1);
    set_src(1, 0, 1, -1);

    // reset state
    repeat (3) @(negedge in_clk);
    #1;
    chk("rst_grant", 32'(out_grant), 0);
    chk("rst_ready", 32'(out_req_ready), 0);
    chk("rst_txen", 32'(out_mac_txen), 0);
    chk("rst_txd", 32'(out_mac_txd), 0);
    chk("rst_underrun", 32'(out_underrun), 0);
    chk("rst_oversize", 32'(out_oversize), 0);
    @(negedge in_clk);
    in_rst = 1'b0;

    // single 60-byte frame from requester 0
    clear_stats();
    set_src(0, 1, 60, -1);
    run(100);
    chk("single_first_txen", 32'(first_txen), 1);
    chk("single_last_txen", 32'(last_txen), 60);
    chk("single_txen_cycles", 32'(txen_cyc), 60);
    chk("single_beats", 32'(beats[0]), 60);
    chk("single_data_err", 32'(data_err), 0);
    chk("single_grant0", 32'(gseq.size() > 0 ? gseq[0] : -1), 0);

    // contention: both requesters, three frames each
    do_reset();
    clear_stats();
    set_src(0, 3, 8, -1);
    set_src(1, 3, 8, -1);
    run(420);
    chk("cont_frames", 32'(done_frames), 6);
    chk("cont_grant_count", 32'(gseq.size()), 6);
    for (int k = 0; k < gseq.size(); k++) chk($sformatf("cont_grant_%0d", k), 32'(gseq[k]), 32'(k % 2));
    chk("cont_gaps", 32'(n_gaps), 5);
    chk("cont_min_gap_ge13", 32'(min_idle >= 13), 1);
    chk("cont_data_err", 32'(data_err), 0);

    // MAC backpressure, ready toggling every cycle
    clear_stats();
    toggle_mode = 1;
    mirror_mode = 1;
    set_src(0, 1, 50, -1);
    run(150);
    toggle_mode = 0;
    mirror_mode = 0;
    chk("bp_beats", 32'(beats[0]), 50);
    chk("bp_data_err", 32'(data_err), 0);
    chk("bp_ready_mirror_err", 32'(mirror_err), 0);
    chk("bp_frames", 32'(done_frames), 1);
    chk("bp_drained", 32'(drained), 0);

    // underrun at byte 20
    clear_stats();
    set_src(0, 1, 40, 20);
    run(60);
    chk("ur_pulses", 32'(under_cnt), 1);
    chk("ur_beats", 32'(beats[0]), 20);
    chk("ur_txen_cycles", 32'(txen_cyc), 21);
    chk("ur_txen_after", 32'(txen_after_under), 0);
    chk("ur_grant_after", 32'(out_grant), 0);
    set_src(0, 0, 1, -1);

    // oversize 1510-byte frame
    clear_stats();
    set_src(0, 1, 1510, -1);
    run(1560);
    chk("ov_beats", 32'(beats[0]), 1500);
    chk("ov_txen_cycles", 32'(txen_cyc), 1500);
    chk("ov_drained", 32'(drained), 10);
    chk("ov_pulses", 32'(over_cnt), 1);
    chk("ov_data_err", 32'(data_err), 0);
    chk("ov_frames", 32'(done_frames), 1);

`ifdef MAC_TX_ARB_PAD_EN
    // 10-byte frame padded to 46
    clear_stats();
    set_src(0, 1, 10, -1);
    run(70);
    chk("pad_txen_cycles", 32'(txen_cyc), 46);
    chk("pad_data_beats", 32'(beats[0]), 10);
    chk("pad_zero_beats", 32'(pad_beats), 36);
    chk("pad_zero_err", 32'(pad_err), 0);
    chk("pad_data_err", 32'(data_err), 0);
`endif

    // reset mid-frame, then requester 0 must win again
    clear_stats();
    set_src(0, 1, 30, -1);
    run(6);
    chk("mr_txen_before", 32'(out_mac_txen), 1);
    @(negedge in_clk);
    in_rst = 1'b1;
    @(negedge in_clk);
    #1;
    chk("mr_txen", 32'(out_mac_txen), 0);
    chk("mr_grant", 32'(out_grant), 0);
    chk("mr_ready", 32'(out_req_ready), 0);
    chk("mr_txd", 32'(out_mac_txd), 0);
    chk("mr_underrun", 32'(out_underrun), 0);
    in_req_valid = '0;
    in_rst = 1'b0;
    clear_stats();
    set_src(0, 1, 4, -1);
    set_src(1, 1, 4, -1);
    run(120);
    chk("mr_grant_count", 32'(gseq.size()), 2);
    chk("mr_first_grant", 32'(gseq.size() > 0 ? gseq[0] : -1), 0);
    chk("mr_second_grant", 32'(gseq.size() > 1 ? gseq[1] : -1), 1);
    chk("mr_frames", 32'(done_frames), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
